dmem_block_mover: RTL

Block-transfer initiator for the 256 x 128-bit data memory. Given a start pulse, it drives the memory's request side (address, write data, write enable, memory enable) to either copy a contiguous block of words from one address range to another, or fill a range with a constant word. It sits beside the processor pipeline on the memory port and is the requesting end of the memory's one-cycle-latency read / same-edge write protocol.

---
 rtl/dmem_block_mover.sv | 77 +++++++
 1 files changed

// File: rtl/dmem_block_mover.sv
// dmem_block_mover: copies or fills a block of words in the 256 x 128-bit data memory.
// Reads lead their writes by one cycle to match the memory's one-cycle read latency.
module dmem_block_mover #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [0:ADDR_WIDTH-1] srcAddr,
    input  logic [0:ADDR_WIDTH-1] dstAddr,
    input  logic [0:ADDR_WIDTH]   len,
    input  logic [0:DATA_WIDTH-1] fillData,
    output logic                  busy,
    output logic                  done,
    output logic                  memEn,
    output logic                  memWrEn,
    output logic [0:ADDR_WIDTH-1] memAddr,
    output logic [0:DATA_WIDTH-1] memDataOut,
    input  logic [0:DATA_WIDTH-1] memDataIn
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [0:ADDR_WIDTH]   ONE_CNT  = 1;
    localparam logic [0:ADDR_WIDTH-1] ONE_ADDR = 1;

    state_t                state, nextState;
    logic                  modeR;
    logic [0:ADDR_WIDTH-1] src, dst;
    logic [0:ADDR_WIDTH]   remain;
    logic [0:DATA_WIDTH-1] fillR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            modeR  <= 1'b0;
            src    <= '0;
            dst    <= '0;
            remain <= '0;
            fillR  <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                modeR  <= mode;
                src    <= srcAddr;
                dst    <= dstAddr;
                remain <= len;
                fillR  <= fillData;
            end else if (state == WR) begin
                remain <= remain - ONE_CNT;
                src    <= src + ONE_ADDR;
                dst    <= dst + ONE_ADDR;
            end
        end
    end

    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = !start ? IDLE : (len == '0) ? DONE : mode ? WR : RD;
            RD:      nextState = WR;
            WR:      nextState = (remain == ONE_CNT) ? DONE : modeR ? WR : RD;
            default: nextState = IDLE;
        endcase
    end

    // Copy write data passes straight through from the word read in the preceding RD cycle.
    always_comb begin
        busy       = state == RD || state == WR;
        done       = state == DONE;
        memEn      = busy;
        memWrEn    = state == WR;
        memAddr    = state == RD ? src : state == WR ? dst : '0;
        memDataOut = state != WR ? '0 : modeR ? fillR : memDataIn;
    end
endmodule
